// File: rtl/div_pkg.sv
// div_pkg: shared state type, default width and two's-complement helpers
// for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_DEFAULT_WIDTH = 32;

    // Helpers work on the widest supported operand and are truncated at the
    // call site, so one function serves every WIDTH up to this limit.
    localparam int DIV_MAX_WIDTH = 64;

    function automatic logic [DIV_MAX_WIDTH-1:0] twos_negate(
        input logic [DIV_MAX_WIDTH-1:0] value
    );
        return ~value + DIV_MAX_WIDTH'(1);
    endfunction

    function automatic logic [DIV_MAX_WIDTH-1:0] twos_abs(
        input logic [DIV_MAX_WIDTH-1:0] value,
        input logic                     is_negative
    );
        return is_negative ? twos_negate(value) : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration. Shifts the next
// dividend bit into the partial remainder and tries a subtraction of the
// divisor, built as an adder with the divisor inverted and carry-in set.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   divisor_inv;
    logic [WIDTH+1:0] sum;
    logic             unused_sum_bit;

    assign shifted     = {rem, dvd_bit};
    assign divisor_inv = ~{1'b0, divisor};

    // a + ~b + 1 : carry out of the top bit means no borrow, i.e. trial >= 0
    assign sum = {1'b0, shifted} + {1'b0, divisor_inv} + {{(WIDTH+1){1'b0}}, 1'b1};

    assign q_bit          = sum[WIDTH+1];
    assign rem_next       = q_bit ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign unused_sum_bit = sum[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock,
// with start/busy/done handshake and fast paths for divide-by-zero and
// signed MIN / -1. Signed operation is compiled in only when the macro
// SEQ_DIVIDER_SIGNED_EN is defined; otherwise every operation is unsigned
// and overflow is tied low. WIDTH must be between 4 and 64.
import div_pkg::*;

module seq_divider #(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    div_state_t       next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dsr_abs;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             is_zero;
    logic             fast_path;
    logic             pend_dz;

    assign is_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sign_mode;
    logic is_ovf;
    logic neg_q;
    logic neg_r;
    logic pend_ov;
    logic overflow_reg;

    assign sign_mode = signed_op;
    assign is_ovf    = sign_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (divisor == '1);
    assign dvd_abs   = WIDTH'(twos_abs(DIV_MAX_WIDTH'(dividend), sign_mode & dividend[WIDTH-1]));
    assign dsr_abs   = WIDTH'(twos_abs(DIV_MAX_WIDTH'(divisor), sign_mode & divisor[WIDTH-1]));
    assign fast_path = is_zero | is_ovf;
    assign overflow  = overflow_reg;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign dvd_abs          = dividend;
    assign dsr_abs          = divisor;
    assign fast_path        = is_zero;
    assign overflow         = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .dvd_bit  (dvd_reg[WIDTH-1]),
        .divisor  (dsr_reg),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: fast paths jump straight to FIX for a one-cycle busy
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = fast_path ? FIX : CALC;
            CALC:    if (count == '0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: busy covers every non-idle cycle, so it is low in the done cycle
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: operand capture, shift-subtract iterations and result writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            rem_reg     <= '0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            pend_dz     <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            pend_ov      <= 1'b0;
            overflow_reg <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        count       <= CW'(WIDTH - 1);
                        dsr_reg     <= dsr_abs;
                        pend_dz     <= is_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        overflow_reg <= 1'b0;
                        pend_ov      <= is_ovf & ~is_zero;
                        neg_q        <= ~fast_path & sign_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r        <= ~fast_path & sign_mode & dividend[WIDTH-1];
`endif
                        if (is_zero) begin
                            dvd_reg <= '1;
                            rem_reg <= dividend;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        end else if (is_ovf) begin
                            dvd_reg <= dividend;
                            rem_reg <= '0;
`endif
                        end else begin
                            dvd_reg <= dvd_abs;
                            rem_reg <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= step_rem;
                    dvd_reg <= {dvd_reg[WIDTH-2:0], step_q};
                    count   <= count - CW'(1);
                end
                FIX: begin
                    count       <= '0;
                    done        <= 1'b1;
                    div_by_zero <= pend_dz;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    overflow_reg <= pend_ov;
                    quotient     <= neg_q ? WIDTH'(twos_negate(DIV_MAX_WIDTH'(dvd_reg))) : dvd_reg;
                    remainder    <= neg_r ? WIDTH'(twos_negate(DIV_MAX_WIDTH'(rem_reg))) : rem_reg;
`else
                    quotient     <= dvd_reg;
                    remainder    <= rem_reg;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed self-checking bench for seq_divider
// (WIDTH=32). A behavioural model derives results from plain arithmetic and
// tracks the expected busy/done timing; the bench honours SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

    localparam int W = 32;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    // Model state
    int           left;
    logic         exp_done;
    logic [W-1:0] exp_q, exp_r, pend_q, pend_r;
    logic         exp_dz, exp_ov, pend_dz, pend_ov;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division from arithmetic rules: truncating signed division,
    // plus the divide-by-zero and MIN / -1 special results.
    function automatic void modelDivide(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                        output logic [W-1:0] q, output logic [W-1:0] r,
                                        output logic dz, output logic ov);
        longint sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sgn && a == MIN_VAL && b == '1) begin
            q  = MIN_VAL;
            r  = '0;
            ov = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Behavioural model: an accepted operation completes after a fixed number
    // of edges (1 for fast paths, W+1 otherwise); starts while busy are dropped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left     = 0;
            exp_done = 1'b0;
            exp_q    = '0;
            exp_r    = '0;
            exp_dz   = 1'b0;
            exp_ov   = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (left == 0) begin
                if (start) begin
                    modelDivide(signed_op & SIGNED_EN, dividend, divisor, pend_q, pend_r, pend_dz, pend_ov);
                    left   = (pend_dz || pend_ov) ? 1 : W + 1;
                    exp_dz = 1'b0;
                    exp_ov = 1'b0;
                end
            end else begin
                left = left - 1;
                if (left == 0) begin
                    exp_done = 1'b1;
                    exp_q    = pend_q;
                    exp_r    = pend_r;
                    exp_dz   = pend_dz;
                    exp_ov   = pend_ov;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        checkOutput("busy", 64'(busy), 64'(left != 0));
        checkOutput("done", 64'(done), 64'(exp_done));
        checkOutput("quotient", 64'(quotient), 64'(exp_q));
        checkOutput("remainder", 64'(remainder), 64'(exp_r));
        checkOutput("div_by_zero", 64'(div_by_zero), 64'(exp_dz));
        checkOutput("overflow", 64'(overflow), 64'(exp_ov));
    end

    // Issue one operation from a falling edge with the DUT idle; optionally
    // pulse a junk start 'poke' edges into the operation. Returns edges from
    // the accept edge to the edge that raised done (bounded).
    task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int poke, output int lat);
        start     = 1'b1;
        signed_op = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == poke) begin
                start     = 1'b1;
                signed_op = ~sgn;
                dividend  = $urandom;
                divisor   = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int mode;
        logic [W-1:0] a, b;
        logic sgn;

        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_quotient", 64'(quotient), 64'd0);
        checkOutput("reset_div_by_zero", 64'(div_by_zero), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] unsigned 100 / 7");
        applyStimulus(1'b0, 32'd100, 32'd7, -1, lat);
        checkOutput("lat_100_7", 64'(lat), 64'd33);
        checkOutput("q_100_7", 64'(quotient), 64'h0000_000E);
        checkOutput("r_100_7", 64'(remainder), 64'h0000_0002);

        $display("[TB] signed -7 / 2, then back-to-back unsigned max / 1");
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, -1, lat);
        if (SIGNED_EN) begin
            checkOutput("q_m7_2", 64'(quotient), 64'hFFFF_FFFD);
            checkOutput("r_m7_2", 64'(remainder), 64'hFFFF_FFFF);
        end else begin
            checkOutput("q_m7_2", 64'(quotient), 64'h7FFF_FFFC);
            checkOutput("r_m7_2", 64'(remainder), 64'h0000_0001);
        end
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, -1, lat);
        checkOutput("lat_back_to_back", 64'(lat), 64'd33);
        checkOutput("q_max_1", 64'(quotient), 64'hFFFF_FFFF);
        checkOutput("r_max_1", 64'(remainder), 64'h0);

        $display("[TB] divide by zero fast path");
        applyStimulus(1'b0, 32'h0000_1234, 32'h0, -1, lat);
        checkOutput("lat_div0", 64'(lat), 64'd1);
        checkOutput("q_div0", 64'(quotient), 64'hFFFF_FFFF);
        checkOutput("r_div0", 64'(remainder), 64'h0000_1234);
        checkOutput("flag_div0", 64'(div_by_zero), 64'd1);
        applyStimulus(1'b0, 32'd9, 32'd3, -1, lat);
        checkOutput("flag_div0_cleared", 64'(div_by_zero), 64'd0);

        $display("[TB] MIN / -1");
        applyStimulus(1'b1, MIN_VAL, 32'hFFFF_FFFF, -1, lat);
        checkOutput("lat_ovf", 64'(lat), SIGNED_EN ? 64'd1 : 64'd33);
        checkOutput("q_ovf", 64'(quotient), SIGNED_EN ? 64'h8000_0000 : 64'h0);
        checkOutput("r_ovf", 64'(remainder), SIGNED_EN ? 64'h0 : 64'h8000_0000);
        checkOutput("flag_ovf", 64'(overflow), SIGNED_EN ? 64'd1 : 64'd0);
        applyStimulus(1'b0, MIN_VAL, 32'hFFFF_FFFF, -1, lat);
        checkOutput("q_min_unsigned", 64'(quotient), 64'h0);
        checkOutput("r_min_unsigned", 64'(remainder), 64'h8000_0000);

        $display("[TB] start while busy is ignored");
        applyStimulus(1'b0, 32'd1000, 32'd33, 5, lat);
        checkOutput("lat_poked", 64'(lat), 64'd33);
        checkOutput("q_poked", 64'(quotient), 64'd30);
        checkOutput("r_poked", 64'(remainder), 64'd10);
        @(negedge clk);

        $display("[TB] reset during CALC");
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd77777;
        divisor   = 32'd13;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_quotient", 64'(quotient), 64'd0);
        checkOutput("abort_remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'd50, 32'd5, -1, lat);
        checkOutput("q_50_5", 64'(quotient), 64'd10);
        checkOutput("r_50_5", 64'(remainder), 64'd0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            if (mode == 0) b = '0;
            else if (mode == 1) begin a = MIN_VAL; b = '1; end
            else if (mode == 2) b = W'($urandom_range(1, 15));
            else if (mode == 3) b = -W'($urandom_range(1, 15));
            applyStimulus(sgn, a, b, (mode == 4) ? 7 : -1, lat);
            checkOutput("lat_random", 64'(lat),
                        (b == '0 || (sgn && SIGNED_EN && a == MIN_VAL && b == '1)) ? 64'd1 : 64'd33);
            if (($urandom_range(0, 3) == 0)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
